csum_stream_arbiter: RTL and testbench
======================================

CSUM_STREAM_ARBITER -- requirements
Module: csum_stream_arbiter

Interface
REQ-001 SHALL have parameter C_AXIS_DATA_WIDTH, default 256, width of every TDATA bus.
REQ-002 SHALL have parameter C_AXIS_TUSER_WIDTH, default 128, width of every TUSER bus.
REQ-003 SHALL have port AXI_ACLK  input  1  single clock; all logic is on its rising edge.
REQ-004 SHALL have port AXI_RESET  input  1  synchronous, active-high reset.
REQ-005 SHALL have, for n = 0..3, S<n>_AXIS_TDATA  input  C_AXIS_DATA_WIDTH  requester n data.
REQ-006 SHALL have, for n = 0..3, S<n>_AXIS_TSTRB  input  C_AXIS_DATA_WIDTH/8  requester n byte strobes.
REQ-007 SHALL have, for n = 0..3, S<n>_AXIS_TUSER  input  C_AXIS_TUSER_WIDTH  requester n sideband.
REQ-008 SHALL have, for n = 0..3, S<n>_AXIS_TVALID input 1, S<n>_AXIS_TLAST input 1 and S<n>_AXIS_TREADY output 1, standard AXI-Stream meaning.
REQ-009 SHALL have M_AXIS_TDATA, M_AXIS_TSTRB and M_AXIS_TUSER as outputs with the widths above, feeding the shared checksum/lookup stage.
REQ-010 SHALL have M_AXIS_TVALID output 1, M_AXIS_TLAST output 1 and M_AXIS_TREADY input 1.
REQ-011 SHALL have GRANT  output  4  one-hot current grant; 0 when idle.
REQ-012 SHALL have PKT_CNT0..PKT_CNT3  output  32 each  count of packets completed per requester.

Function
REQ-013 SHALL implement an FSM with two states: IDLE and SEND.
REQ-014 In IDLE, when any S<n>_AXIS_TVALID is 1, SHALL select the first asserting port in round-robin order, starting at (LAST+1) mod 4, where LAST is the most recently served port.
REQ-015 SHALL register the selected port into GRANT and enter SEND at the next edge, giving one cycle of arbitration latency.
REQ-016 In IDLE, SHALL hold GRANT = 0, M_AXIS_TVALID = 0 and all S<n>_AXIS_TREADY = 0.
REQ-017 In SEND, SHALL drive M_AXIS_TDATA, TSTRB, TUSER, TVALID and TLAST combinationally from granted port g.
REQ-018 In SEND, SHALL drive S<g>_AXIS_TREADY = M_AXIS_TREADY and every other S<n>_AXIS_TREADY = 0.
REQ-019 In SEND, SHALL hold the grant until a beat with M_AXIS_TVALID & M_AXIS_TREADY & M_AXIS_TLAST.
REQ-020 On that last beat, SHALL return to IDLE, set LAST = g and increment PKT_CNT<g> by 1, all at the same edge.
REQ-021 SHALL handle single-beat packets (TLAST on the first beat) by completing them exactly as in REQ-020.
REQ-022 SHALL NOT change the grant mid-packet when the granted TVALID deasserts; the M side simply shows no valid beat.
REQ-023 SHALL NOT change the grant mid-packet when other requesters assert.
REQ-024 SHALL wrap each PKT_CNT from 0xFFFFFFFF to 0 without saturation or a flag.
REQ-025 SHALL insert exactly one IDLE cycle between consecutive packets, so peak throughput is one packet per (beats + 1) cycles.
REQ-026 SHALL keep M_AXIS_* stable while M_AXIS_TVALID = 1 and M_AXIS_TREADY = 0, provided the granted requester obeys AXI-Stream.
REQ-027 When the only requester is the last-served port, SHALL grant that port again.
REQ-028 SHALL drive all M_AXIS data/sideband outputs to 0 in IDLE.

Reset
REQ-029 On AXI_RESET = 1 at a clock edge, SHALL set state = IDLE, GRANT = 0, LAST = 3 (port 0 has first priority) and all PKT_CNT = 0.
REQ-030 On that same reset edge, SHALL hold all S<n>_AXIS_TREADY = 0 and M_AXIS_TVALID = 0.
REQ-031 A reset asserted mid-packet SHALL abandon the packet with no count increment; the remaining beats of that packet are the requester's responsibility.
REQ-032 Reset SHALL take priority over every other event in the same cycle.

Verification
REQ-033 Bench: reset, then S1 sends a 3-beat packet with M_AXIS_TREADY = 1 -> GRANT = 0010 one cycle after S1 TVALID; 3 beats out; PKT_CNT1 = 1; IDLE on the next cycle.
REQ-034 Bench: all four ports continuously offer 2-beat packets -> grant order is 0,1,2,3,0; one idle cycle between packets; each PKT_CNT = 2 after 8 packets.
REQ-035 Bench: M_AXIS_TREADY low for 5 cycles mid-packet on port 2 -> data held stable, S2 TREADY = 0 during the stall, no other port granted, count increments only after TLAST.
REQ-036 Bench: port 3 sends single-beat packets while port 0 is idle -> port 3 is re-granted each time; PKT_CNT3 increments per packet.
REQ-037 Bench: preload or force PKT_CNT0 = 0xFFFFFFFF and complete one port-0 packet -> PKT_CNT0 = 0.
REQ-038 Bench: assert AXI_RESET on beat 2 of a 4-beat port-1 packet -> next cycle GRANT = 0 and PKT_CNT1 = 0; a fresh request from port 0 and port 1 together is granted to port 0.

Source files
------------

// File: rtl/csum_stream_arbiter.sv
// csum_stream_arbiter: 4:1 round-robin AXI-Stream packet arbiter feeding the shared checksum/lookup stage
// Ports: AXI_ACLK clock, AXI_RESET sync active-high reset; S0..S3_AXIS_* requester streams;
// M_AXIS_* arbitrated output stream; GRANT one-hot current grant (0 when idle);
// PKT_CNT0..PKT_CNT3 wrapping per-requester count of completed packets.
module csum_stream_arbiter #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128
) (
  input  logic                            AXI_ACLK,
  input  logic                            AXI_RESET,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    S0_AXIS_TDATA,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  S0_AXIS_TSTRB,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   S0_AXIS_TUSER,
  input  logic                            S0_AXIS_TVALID,
  input  logic                            S0_AXIS_TLAST,
  output logic                            S0_AXIS_TREADY,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    S1_AXIS_TDATA,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  S1_AXIS_TSTRB,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   S1_AXIS_TUSER,
  input  logic                            S1_AXIS_TVALID,
  input  logic                            S1_AXIS_TLAST,
  output logic                            S1_AXIS_TREADY,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    S2_AXIS_TDATA,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  S2_AXIS_TSTRB,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   S2_AXIS_TUSER,
  input  logic                            S2_AXIS_TVALID,
  input  logic                            S2_AXIS_TLAST,
  output logic                            S2_AXIS_TREADY,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    S3_AXIS_TDATA,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  S3_AXIS_TSTRB,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   S3_AXIS_TUSER,
  input  logic                            S3_AXIS_TVALID,
  input  logic                            S3_AXIS_TLAST,
  output logic                            S3_AXIS_TREADY,
  output logic [C_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                            M_AXIS_TVALID,
  output logic                            M_AXIS_TLAST,
  input  logic                            M_AXIS_TREADY,
  output logic [3:0]                      GRANT,
  output logic [31:0]                     PKT_CNT0,
  output logic [31:0]                     PKT_CNT1,
  output logic [31:0]                     PKT_CNT2,
  output logic [31:0]                     PKT_CNT3
);
  localparam int SW = C_AXIS_DATA_WIDTH / 8;
  typedef enum logic {IDLE, SEND} state_t;
  state_t state_q, state_d;
  logic [1:0] gnt_q, gnt_d, last_q, last_d, idx;
  logic [3:0][31:0] cnt_q, cnt_d;
  logic [3:0] vld, lst;
  logic [C_AXIS_DATA_WIDTH-1:0] dat [4];
  logic [SW-1:0] stb [4];
  logic [C_AXIS_TUSER_WIDTH-1:0] usr [4];
  logic send, found;
  assign vld = {S3_AXIS_TVALID, S2_AXIS_TVALID, S1_AXIS_TVALID, S0_AXIS_TVALID};
  assign lst = {S3_AXIS_TLAST, S2_AXIS_TLAST, S1_AXIS_TLAST, S0_AXIS_TLAST};
  assign dat = '{S0_AXIS_TDATA, S1_AXIS_TDATA, S2_AXIS_TDATA, S3_AXIS_TDATA};
  assign stb = '{S0_AXIS_TSTRB, S1_AXIS_TSTRB, S2_AXIS_TSTRB, S3_AXIS_TSTRB};
  assign usr = '{S0_AXIS_TUSER, S1_AXIS_TUSER, S2_AXIS_TUSER, S3_AXIS_TUSER};
  // Reset wins over everything: outputs are quiet during the reset cycle itself.
  assign send = (state_q == SEND) && !AXI_RESET;
  // Search starts at last+1; i = 4 wraps back to last so a lone last-served requester is re-granted.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    found   = 1'b0;
    idx     = '0;
    if (state_q == IDLE) begin
      for (int i = 1; i <= 4; i++) begin
        idx = last_q + 2'(i);
        if (vld[idx] && !found) begin
          found = 1'b1;
          gnt_d = idx;
        end
      end
      state_d = found ? SEND : IDLE;
    end else if (vld[gnt_q] && M_AXIS_TREADY && lst[gnt_q]) begin
      state_d         = IDLE;
      last_d          = gnt_q;
      cnt_d[gnt_q]    = cnt_q[gnt_q] + 32'd1;
    end
  end
  always_ff @(posedge AXI_ACLK) begin
    if (AXI_RESET) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= 2'd3;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end
  assign M_AXIS_TDATA   = send ? dat[gnt_q] : '0;
  assign M_AXIS_TSTRB   = send ? stb[gnt_q] : '0;
  assign M_AXIS_TUSER   = send ? usr[gnt_q] : '0;
  assign M_AXIS_TVALID  = send && vld[gnt_q];
  assign M_AXIS_TLAST   = send && lst[gnt_q];
  assign GRANT          = send ? (4'b0001 << gnt_q) : 4'b0000;
  assign S0_AXIS_TREADY = send && (gnt_q == 2'd0) && M_AXIS_TREADY;
  assign S1_AXIS_TREADY = send && (gnt_q == 2'd1) && M_AXIS_TREADY;
  assign S2_AXIS_TREADY = send && (gnt_q == 2'd2) && M_AXIS_TREADY;
  assign S3_AXIS_TREADY = send && (gnt_q == 2'd3) && M_AXIS_TREADY;
  assign PKT_CNT0 = cnt_q[0];
  assign PKT_CNT1 = cnt_q[1];
  assign PKT_CNT2 = cnt_q[2];
  assign PKT_CNT3 = cnt_q[3];
endmodule

// File: tb/tb_csum_stream_arbiter.sv
// tb_csum_stream_arbiter: directed and randomized checks of csum_stream_arbiter against a packet-level model
module tb_csum_stream_arbiter;
  localparam int DW = 256;
  localparam int UW = 128;
  localparam int SW = DW / 8;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic [DW-1:0] s_tdata [4];
  logic [SW-1:0] s_tstrb [4];
  logic [UW-1:0] s_tuser [4];
  logic [3:0] s_tvalid, s_tlast, s_tready;
  logic [DW-1:0] m_tdata;
  logic [SW-1:0] m_tstrb;
  logic [UW-1:0] m_tuser;
  logic m_tvalid, m_tlast, m_tready;
  logic [3:0] grant;
  logic [31:0] pc [4];
  csum_stream_arbiter dut (
    .AXI_ACLK(clk), .AXI_RESET(rst),
    .S0_AXIS_TDATA(s_tdata[0]), .S0_AXIS_TSTRB(s_tstrb[0]), .S0_AXIS_TUSER(s_tuser[0]),
    .S0_AXIS_TVALID(s_tvalid[0]), .S0_AXIS_TLAST(s_tlast[0]), .S0_AXIS_TREADY(s_tready[0]),
    .S1_AXIS_TDATA(s_tdata[1]), .S1_AXIS_TSTRB(s_tstrb[1]), .S1_AXIS_TUSER(s_tuser[1]),
    .S1_AXIS_TVALID(s_tvalid[1]), .S1_AXIS_TLAST(s_tlast[1]), .S1_AXIS_TREADY(s_tready[1]),
    .S2_AXIS_TDATA(s_tdata[2]), .S2_AXIS_TSTRB(s_tstrb[2]), .S2_AXIS_TUSER(s_tuser[2]),
    .S2_AXIS_TVALID(s_tvalid[2]), .S2_AXIS_TLAST(s_tlast[2]), .S2_AXIS_TREADY(s_tready[2]),
    .S3_AXIS_TDATA(s_tdata[3]), .S3_AXIS_TSTRB(s_tstrb[3]), .S3_AXIS_TUSER(s_tuser[3]),
    .S3_AXIS_TVALID(s_tvalid[3]), .S3_AXIS_TLAST(s_tlast[3]), .S3_AXIS_TREADY(s_tready[3]),
    .M_AXIS_TDATA(m_tdata), .M_AXIS_TSTRB(m_tstrb), .M_AXIS_TUSER(m_tuser),
    .M_AXIS_TVALID(m_tvalid), .M_AXIS_TLAST(m_tlast), .M_AXIS_TREADY(m_tready),
    .GRANT(grant), .PKT_CNT0(pc[0]), .PKT_CNT1(pc[1]), .PKT_CNT2(pc[2]), .PKT_CNT3(pc[3])
  );
  int total, bad, cycle;
  int pend [4], plen [4], cur_len [4], bidx [4], pseq [4], beats_seen [4];
  logic [31:0] cur_rnd [4];
  bit started [4], hold [4], hs [4];
  bit rnd_hold;
  bit busy, after_last;
  int exp_g, exp_last, d_first;
  logic [31:0] exp_cnt [4];
  logic [3:0] prev_req, prev_g, g_s, tr_s;
  logic [DW-1:0] md_s, stall_ref;
  int dlog [$];
  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [DW-1:0] sdat(int n);
    return {{7{cur_rnd[n]}}, 8'(n), 8'(pseq[n]), 16'(bidx[n])};
  endfunction
  function automatic logic [UW-1:0] susr(int n);
    return {cur_rnd[n], ~cur_rnd[n], 32'(n), 32'(bidx[n])};
  endfunction
  function automatic int rr(logic [3:0] req, int last);
    for (int k = 1; k <= 4; k++) if (req[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction
  task automatic drive();
    for (int n = 0; n < 4; n++) begin
      if (pend[n] > 0 && !started[n]) begin
        started[n] = 1;
        cur_len[n] = plen[n] > 0 ? plen[n] : int'($urandom_range(1, 4));
        cur_rnd[n] = $urandom;
        pseq[n]++;
        bidx[n] = 0;
      end
      s_tvalid[n] = started[n] && !hold[n];
      s_tdata[n]  = started[n] ? sdat(n) : '0;
      s_tuser[n]  = started[n] ? susr(n) : '0;
      s_tstrb[n]  = started[n] ? cur_rnd[n] : '0;
      s_tlast[n]  = started[n] && (bidx[n] == cur_len[n] - 1);
    end
  endtask
  task automatic clear_src();
    for (int n = 0; n < 4; n++) begin
      pend[n] = 0; started[n] = 0; bidx[n] = 0; hold[n] = 0; beats_seen[n] = 0;
    end
  endtask
  task automatic cyc();
    @(negedge clk);
    cycle++;
    g_s = grant; tr_s = s_tready; md_s = m_tdata;
    for (int n = 0; n < 4; n++) hs[n] = s_tready[n] && s_tvalid[n];
    if (rst) begin
      chk("rst_tvalid", m_tvalid, 0);
      chk("rst_tready", s_tready, 0);
      chk("rst_grant", grant, 0);
      busy = 0; after_last = 0; exp_last = 3; prev_req = 0; prev_g = 0;
      for (int n = 0; n < 4; n++) begin exp_cnt[n] = 0; hs[n] = 0; end
    end else begin
      for (int n = 0; n < 4; n++) chk($sformatf("pkt_cnt%0d", n), pc[n], exp_cnt[n]);
      if (grant != 0 && prev_g == 0)
        for (int k = 0; k < 4; k++) if (grant[k]) begin
          dlog.push_back(k);
          if (dlog.size() == 1) d_first = cycle;
        end
      prev_g = grant;
      if (!busy && !after_last && prev_req != 0) begin
        exp_g = rr(prev_req, exp_last);
        busy = 1;
      end
      after_last = 0;
      if (busy) begin
        chk("grant", grant, 4'b0001 << exp_g);
        chk("m_tvalid", m_tvalid, s_tvalid[exp_g]);
        chk("s_tready", s_tready, m_tready ? (4'b0001 << exp_g) : 4'b0000);
        if (s_tvalid[exp_g]) begin
          chk("m_tdata", m_tdata, sdat(exp_g));
          chk("m_tuser", m_tuser, susr(exp_g));
          chk("m_tstrb", m_tstrb, cur_rnd[exp_g]);
          chk("m_tlast", m_tlast, s_tlast[exp_g]);
          if (m_tready) begin
            beats_seen[exp_g]++;
            if (s_tlast[exp_g]) begin
              busy = 0; exp_cnt[exp_g]++; exp_last = exp_g; after_last = 1;
            end
          end
        end
      end else begin
        chk("idle_grant", grant, 0);
        chk("idle_tvalid", m_tvalid, 0);
        chk("idle_tready", s_tready, 0);
        chk("idle_tdata", m_tdata, 0);
        chk("idle_tuser", m_tuser, 0);
        chk("idle_tstrb", m_tstrb, 0);
        chk("idle_tlast", m_tlast, 0);
      end
      prev_req = s_tvalid;
    end
    @(posedge clk);
    #1;
    for (int n = 0; n < 4; n++) begin
      if (hs[n]) begin
        bidx[n]++;
        if (bidx[n] == cur_len[n]) begin bidx[n] = 0; pend[n]--; started[n] = 0; end
      end
      if (hs[n] || hold[n] || !started[n]) hold[n] = rnd_hold && ($urandom_range(0, 3) == 0);
    end
    drive();
  endtask
  task automatic do_reset();
    rst = 1;
    clear_src();
    drive();
    cyc();
    rst = 0;
    dlog.delete();
  endtask
  initial begin
    int c0, issued, psum, csum;
    rst = 1; m_tready = 1; rnd_hold = 0;
    clear_src();
    drive();
    cyc();
    do_reset();
    // S1 three-beat packet
    pend[1] = 1; plen[1] = 3; drive();
    cyc(); chk("a_arb_cycle_grant", g_s, 0);
    cyc(); chk("a_grant_s1", g_s, 4'b0010);
    cyc(); cyc(); cyc();
    chk("a_back_idle", g_s, 0);
    chk("a_cnt1", pc[1], 1);
    chk("a_beats", beats_seen[1], 3);
    // all four ports offering 2-beat packets
    do_reset();
    for (int n = 0; n < 4; n++) begin pend[n] = 2; plen[n] = 2; end
    drive();
    for (int i = 0; i < 80 && pc[3] != 2; i++) cyc();
    chk("b_order_len", dlog.size(), 8);
    for (int i = 0; i < 5; i++) chk("b_order", i < dlog.size() ? dlog[i] : -1, i % 4);
    for (int n = 0; n < 4; n++) chk("b_cnt", pc[n], 2);
    chk("b_span", cycle - d_first, 22);
    // port 2 stalled mid-packet while port 0 requests
    dlog.delete();
    for (int n = 0; n < 4; n++) beats_seen[n] = 0;
    pend[2] = 1; plen[2] = 4; drive();
    for (int i = 0; i < 20 && beats_seen[2] < 2; i++) cyc();
    chk("c_reach_beat2", beats_seen[2], 2);
    c0 = exp_cnt[2];
    m_tready = 0; pend[0] = 1; plen[0] = 1; drive();
    stall_ref = sdat(2);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("c_hold_data", md_s, stall_ref);
      chk("c_hold_grant", g_s, 4'b0100);
      chk("c_stall_tready", tr_s, 0);
      chk("c_stall_cnt", pc[2], c0);
    end
    m_tready = 1;
    for (int i = 0; i < 20 && pc[0] != 3; i++) cyc();
    chk("c_cnt2", pc[2], c0 + 1);
    chk("c_cnt0", pc[0], 3);
    chk("c_order_len", dlog.size(), 2);
    chk("c_order0", dlog.size() > 0 ? dlog[0] : -1, 2);
    chk("c_order1", dlog.size() > 1 ? dlog[1] : -1, 0);
    // port 3 alone with single-beat packets
    do_reset();
    pend[3] = 3; plen[3] = 1; drive();
    for (int i = 0; i < 40 && pc[3] != 3; i++) cyc();
    chk("d_cnt3", pc[3], 3);
    chk("d_grants", dlog.size(), 3);
    foreach (dlog[i]) chk("d_regrant3", dlog[i], 3);
    // PKT_CNT0 wrap from all-ones
    force dut.cnt_q = {32'd3, 32'd0, 32'd0, 32'hFFFF_FFFF};
    exp_cnt[0] = 32'hFFFF_FFFF;
    cyc();
    release dut.cnt_q;
    chk("e_preload", pc[0], 32'hFFFF_FFFF);
    pend[0] = 1; plen[0] = 2; drive();
    for (int i = 0; i < 20 && pc[0] != 0; i++) cyc();
    chk("e_wrap", pc[0], 0);
    chk("e_cnt3_kept", pc[3], 3);
    // reset in the middle of a 4-beat port-1 packet
    do_reset();
    pend[1] = 1; plen[1] = 4; drive();
    for (int i = 0; i < 20 && beats_seen[1] < 1; i++) cyc();
    chk("f_reach_beat2", beats_seen[1], 1);
    rst = 1;
    cyc();
    rst = 0;
    clear_src();
    dlog.delete();
    pend[0] = 1; pend[1] = 1; plen[0] = 1; plen[1] = 1; drive();
    cyc();
    chk("f_grant_after_rst", g_s, 0);
    chk("f_cnt1", pc[1], 0);
    cyc();
    chk("f_grant0", g_s, 4'b0001);
    for (int i = 0; i < 10 && pc[1] != 1; i++) cyc();
    chk("f_cnt1_done", pc[1], 1);
    // randomized traffic, bubbles and back-pressure
    do_reset();
    rnd_hold = 1; issued = 0;
    for (int i = 0; i < 600; i++) begin
      m_tready = $urandom_range(0, 3) != 0;
      for (int n = 0; n < 4; n++)
        if (pend[n] == 0 && $urandom_range(0, 7) == 0) begin
          pend[n] = $urandom_range(1, 3); plen[n] = 0; issued += pend[n];
        end
      drive();
      cyc();
    end
    rnd_hold = 0; m_tready = 1;
    for (int n = 0; n < 4; n++) hold[n] = 0;
    drive();
    psum = 1;
    for (int i = 0; i < 400 && (psum != 0 || busy); i++) begin
      cyc();
      psum = pend[0] + pend[1] + pend[2] + pend[3];
    end
    chk("g_drained", psum, 0);
    csum = 0;
    for (int n = 0; n < 4; n++) begin
      chk("g_cnt", pc[n], exp_cnt[n]);
      csum += int'(pc[n]);
    end
    chk("g_total_pkts", csum, issued);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
